// File: rtl/ahbl_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge.
// Holds the bridge FSM state encoding, AHB HTRANS/HSIZE/HRESP codes.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_apb_bridge_if.sv
// Signal bundle between an AHB-Lite master/decoder plus APB completer on one side
// and the bridge on the other.
//   slave  : bridge view (AHB inputs, PRDATA/PREADY/PSLVERR in; HREADYOUT/HRDATA/HRESP
//            and the APB request signals out)
//   master : environment view (the mirror image)
interface ahbl_apb_bridge_if #(
  parameter int unsigned PADDR_W = 16
) ();

  // AHB-Lite side
  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic [31:0]        HRDATA;
  logic               HRESP;

  // APB side
  logic [PADDR_W-1:0] PADDR;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRDATA, HRESP,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRDATA, HRESP,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB requester bridge. Word-sized transfers only; any other HSIZE
// gets a two-cycle AHB ERROR without touching APB. Stalled APB accesses are aborted
// with an ERROR after TIMEOUT wait cycles (TIMEOUT = 0 disables this).
// Ports:
//   HCLK   - clock, rising edge
//   HRESET - asynchronous active-high reset
//   bus    - ahbl_apb_bridge_if.slave: AHB-Lite slave port plus APB requester port
// PADDR_W must match the interface PADDR_W and be below 32.
module ahbl_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int unsigned PADDR_W = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              HCLK,
  input logic              HRESET,
  ahbl_apb_bridge_if.slave bus
);

  // Keep at least one counter bit so TIMEOUT = 0 still elaborates.
  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [PADDR_W-1:0]   paddr_q;
  logic                 pwrite_q;
  logic [31:0]          pwdata_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 hreadyout_q;
  logic                 hresp_q;
  logic [31:0]          hrdata_q;

  logic accept;
  logic unused_haddr;

  assign accept = bus.HSEL & bus.HREADY &
                  ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ));

  // Only the low PADDR_W address bits reach APB.
  assign unused_haddr = ^bus.HADDR[31:PADDR_W];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      unique case (state_q)
        // ERR2 is the second (ready) error cycle, so it accepts like IDLE.
        StIdle, StErr2: begin
          if (accept) begin
            paddr_q     <= bus.HADDR[PADDR_W-1:0];
            pwrite_q    <= bus.HWRITE;
            hreadyout_q <= 1'b0;
            if (bus.HSIZE != HSIZE_WORD) begin
              state_q <= StErr1;
              hresp_q <= HRESP_ERROR;
            end else if (bus.HWRITE) begin
              state_q <= StWdata;
              hresp_q <= HRESP_OKAY;
            end else begin
              state_q <= StSetup;
              hresp_q <= HRESP_OKAY;
              psel_q  <= 1'b1;
              cnt_q   <= '0;
            end
          end else begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        StWdata: begin
          pwdata_q <= bus.HWDATA;
          state_q  <= StSetup;
          psel_q   <= 1'b1;
          cnt_q    <= '0;
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (bus.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (bus.PSLVERR) begin
              state_q <= StErr1;
              hresp_q <= HRESP_ERROR;
            end else begin
              state_q     <= StIdle;
              hreadyout_q <= 1'b1;
              if (!pwrite_q) hrdata_q <= bus.PRDATA;
            end
          end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
            // Completer never answered: abandon the access and report ERROR.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= StErr1;
            hresp_q   <= HRESP_ERROR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= StIdle;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Scoreboard bench for ahbl_apb_bridge (TIMEOUT = 4). The stimulus process issues AHB
// transfers and queues the expected response; a monitor detects each accepted transfer
// from the bus, tracks its APB activity and checks it when HREADYOUT returns high.
module tb_ahbl_apb_bridge;
  import ahbl_apb_pkg::*;

  typedef struct {
    string       name;
    logic        resp;
    logic [31:0] rdata;
    int          lat;
    int          psel_cyc;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;
  logic hready_lo;
  int   wait_n;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  bit   in_flight = 1'b0;
  int   cyc, psel_cnt, apb_bad;
  logic prev_resp;

  ahbl_apb_bridge_if #(.PADDR_W(16)) bus ();

  ahbl_apb_bridge #(
    .PADDR_W(16),
    .TIMEOUT(4)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  // Single slave on the bus: HREADY follows HREADYOUT unless forced low.
  assign bus.HREADY = hready_lo ? 1'b0 : bus.HREADYOUT;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end
  endtask

  // APB completer: PREADY rises after wait_n ACCESS wait cycles.
  initial begin
    int acc_cnt;
    acc_cnt    = 0;
    bus.PREADY = 1'b0;
    forever begin
      @(posedge HCLK);
      #1;
      if (bus.PSEL && bus.PENABLE) begin
        bus.PREADY = (acc_cnt >= wait_n);
        acc_cnt++;
      end else begin
        bus.PREADY = 1'b0;
        acc_cnt    = 0;
      end
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        in_flight = 1'b0;
        exp_q.delete();
      end else begin
        if (in_flight) begin
          cyc++;
          if (bus.PSEL) begin
            if (exp_q.size() != 0) begin
              e = exp_q[0];
              if (bus.PADDR !== e.paddr || bus.PWRITE !== e.pwrite ||
                  (e.pwrite && bus.PWDATA !== e.pwdata) ||
                  bus.PENABLE !== (psel_cnt != 0))
                apb_bad++;
            end
            psel_cnt++;
          end
          if (bus.HREADYOUT) begin
            in_flight = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected completion", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk({e.name, " hresp"}, {30'd0, prev_resp, bus.HRESP}, {30'd0, e.resp, e.resp});
              chk({e.name, " latency"}, cyc, e.lat);
              chk({e.name, " hrdata"}, bus.HRDATA, e.rdata);
              chk({e.name, " psel cycles"}, psel_cnt, e.psel_cyc);
              chk({e.name, " apb fields"}, apb_bad, 0);
            end
          end else begin
            prev_resp = bus.HRESP;
          end
        end
        if (!in_flight && bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
          if (exp_q.size() == 0) chk("unexpected accept", 32'd1, 32'd0);
          in_flight = 1'b1;
          cyc       = 0;
          psel_cnt  = 0;
          apb_bad   = 0;
          prev_resp = 1'b0;
        end
      end
    end
  end

  // Called at the drive point (#1 after a rising edge); returns at the next drive point.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
    int n = 0;
    bus.HSEL   = 1'b1;
    bus.HADDR  = addr;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    @(negedge HCLK);
    while (!bus.HREADY && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!bus.HREADY) chk("address phase never accepted", 32'd0, 32'd1);
    @(posedge HCLK);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = wdata;
  endtask

  task automatic issue(input string nm, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata, input int wt,
                       input logic slverr, input logic [31:0] prdata, input int lat,
                       input logic resp, input int psel_cyc, input logic [31:0] rdata);
    exp_t e;
    wait_n      = wt;
    bus.PSLVERR = slverr;
    bus.PRDATA  = prdata;
    e.name      = nm;
    e.resp      = resp;
    e.rdata     = rdata;
    e.lat       = lat;
    e.psel_cyc  = psel_cyc;
    e.paddr     = addr[15:0];
    e.pwrite    = wr;
    e.pwdata    = wdata;
    exp_q.push_back(e);
    ahb_xfer(wr, addr, size, wdata);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge HCLK);
      #2;
      n++;
    end while ((in_flight || exp_q.size() != 0) && n < 100);
    if (in_flight || exp_q.size() != 0) begin
      chk("response never arrived", 32'd0, 32'd1);
      in_flight = 1'b0;
      exp_q.delete();
    end
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [1:0] ig_trans [4];
    logic       ig_sel   [4];
    logic       ig_hrlo  [4];
    int n;

    HRESET      = 1'b1;
    hready_lo   = 1'b0;
    wait_n      = 0;
    bus.HSEL    = 1'b0;
    bus.HADDR   = '0;
    bus.HTRANS  = HTRANS_IDLE;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = HSIZE_WORD;
    bus.HWDATA  = '0;
    bus.PRDATA  = '0;
    bus.PSLVERR = 1'b0;

    #3;
    chk("reset HREADYOUT", bus.HREADYOUT, 1);
    chk("reset HRESP", bus.HRESP, 0);
    chk("reset PSEL", bus.PSEL, 0);
    chk("reset PENABLE", bus.PENABLE, 0);
    chk("reset PWRITE", bus.PWRITE, 0);
    chk("reset PADDR", bus.PADDR, 0);
    chk("reset PWDATA", bus.PWDATA, 0);
    chk("reset HRDATA", bus.HRDATA, 0);
    repeat (2) @(negedge HCLK);
    #1 HRESET = 1'b0;
    @(posedge HCLK);
    #1;

    //    name            wr   addr           size    wdata          wt  err  prdata        lat rsp psel rdata
    issue("read ok",      0, 32'h4000_0010, 3'b010, 32'h0,          0, 0, 32'hCAFE_F00D, 3, 0, 2, 32'hCAFE_F00D);
    wait_idle();
    issue("write wait2",  1, 32'h4000_0004, 3'b010, 32'h1234_5678,  2, 0, 32'h1111_1111, 6, 0, 4, 32'hCAFE_F00D);
    wait_idle();
    issue("read slverr",  0, 32'h4000_0008, 3'b010, 32'h0,          0, 1, 32'hDEAD_DEAD, 4, 1, 2, 32'hCAFE_F00D);
    wait_idle();
    issue("byte write",   1, 32'h4000_0020, 3'b000, 32'hFFFF_FFFF,  0, 0, 32'h0,         2, 1, 0, 32'hCAFE_F00D);
    wait_idle();
    issue("timeout read", 0, 32'h4000_0040, 3'b010, 32'h0,       1000, 0, 32'h2222_2222, 7, 1, 5, 32'hCAFE_F00D);
    wait_idle();
    // Second transfer waits through ERR1 and is taken in ERR2.
    issue("half read",    0, 32'h4000_0030, 3'b001, 32'h0,          0, 0, 32'h0,         2, 1, 0, 32'hCAFE_F00D);
    issue("read in err2", 0, 32'h4000_0014, 3'b010, 32'h0,          0, 0, 32'h55AA_33CC, 3, 0, 2, 32'h55AA_33CC);
    wait_idle();

    // Transfers that must be ignored: IDLE, BUSY, HSEL=0, HREADY=0.
    ig_trans = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_NONSEQ};
    ig_sel   = '{1'b1, 1'b1, 1'b0, 1'b1};
    ig_hrlo  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.HSEL   = ig_sel[i];
      bus.HADDR  = 32'h4000_0050;
      bus.HTRANS = ig_trans[i];
      bus.HWRITE = 1'b0;
      bus.HSIZE  = HSIZE_WORD;
      hready_lo  = ig_hrlo[i];
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk($sformatf("ignore %0d ready/psel/resp", i),
          {29'd0, dut.bus.HREADYOUT, bus.PSEL, bus.HRESP}, 32'b100);
      bus.HSEL   = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
      @(posedge HCLK);
      #1;
      hready_lo  = 1'b0;
    end

    // Reset in the middle of a stalled ACCESS.
    issue("read cut by reset", 0, 32'h4000_0060, 3'b010, 32'h0, 1000, 0, 32'h3333_3333,
          3, 0, 2, 32'h0);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!(bus.PSEL && bus.PENABLE) && n < 20);
    chk("reached ACCESS before reset", {31'd0, bus.PENABLE}, 1);
    #2 HRESET = 1'b1;
    #1;
    chk("async reset PSEL", bus.PSEL, 0);
    chk("async reset PENABLE", bus.PENABLE, 0);
    chk("async reset HREADYOUT", bus.HREADYOUT, 1);
    @(negedge HCLK);
    #1 HRESET = 1'b0;
    chk("HRDATA cleared by reset", bus.HRDATA, 0);
    @(posedge HCLK);
    #1;

    issue("read after reset", 0, 32'h4000_0018, 3'b010, 32'h0,      0, 0, 32'h0BAD_BEEF, 3, 0, 2, 32'h0BAD_BEEF);
    wait_idle();
    issue("write fast",       1, 32'h4000_0000, 3'b010, 32'hAAAA_5555, 0, 0, 32'h4444_4444, 4, 0, 2, 32'h0BAD_BEEF);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
